// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Hazard and stall controller for a 5-stage MIPS pipeline. It sits beside ID,
// watches the ID and EX fields, and drives the PC / IF/ID / ID/EX enables,
// the IF/ID flush and the two control-bubble mux selects.
//
// State | meaning
// ------+-----------------------------------------------------------------
// RUN       | normal issue; branch > load-use > jump > mult priority
// MULT_WAIT | multiplier holds EX; front end frozen while cnt != 0
//
// Ports
//   Clk, Reset        pipeline clock, synchronous active-low reset
//   ID_*              rs/rt fields and class flags of the instruction in ID
//   EX_*              load flag, destination and branch outcome in EX
//   PCWrite, IFIDWrite, IDEXWrite   stage load enables
//   IFIDFlush         IF/ID cleared to nop on the next edge
//   CtrlBubbleSel     1 = zero control into ID/EX
//   MemBubbleSel      1 = zero control into EX/MEM
//   MultBusy          multiplier occupies EX
//   StallCycles       saturating count of cycles with PCWrite=0
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [4:0]             ID_Rs,
    input  logic [4:0]             ID_Rt,
    input  logic                   ID_UsesRt,
    input  logic                   ID_IsMult,
    input  logic                   ID_Jump,
    input  logic                   EX_MemRead,
    input  logic [4:0]             EX_Rd,
    input  logic                   EX_BranchTaken,
    output logic                   PCWrite,
    output logic                   IFIDWrite,
    output logic                   IFIDFlush,
    output logic                   IDEXWrite,
    output logic                   CtrlBubbleSel,
    output logic                   MemBubbleSel,
    output logic                   MultBusy,
    output logic [STALL_CNT_W-1:0] StallCycles
);

    localparam int CNT_W = $clog2(MULT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_MULT_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_lu;

    assign w_lu = EX_MemRead & (EX_Rd != 5'd0) &
                  ((EX_Rd == ID_Rs) | (ID_UsesRt & (EX_Rd == ID_Rt)));

    always_comb begin
        PCWrite       = 1'b1;
        IFIDWrite     = 1'b1;
        IDEXWrite     = 1'b1;
        IFIDFlush     = 1'b0;
        CtrlBubbleSel = 1'b0;
        MemBubbleSel  = 1'b0;
        MultBusy      = 1'b0;
        w_state_nxt   = ST_RUN;
        w_cnt_nxt     = r_cnt;

        if (!Reset) begin
            // Hold the whole front end and inject bubbles while in reset.
            PCWrite       = 1'b0;
            IFIDWrite     = 1'b0;
            IDEXWrite     = 1'b0;
            CtrlBubbleSel = 1'b1;
            MemBubbleSel  = 1'b1;
            w_cnt_nxt     = '0;
        end else if (r_state == ST_MULT_WAIT && r_cnt != '0) begin
            // EX holds the mult, so ID inputs and branch outcome are moot.
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IDEXWrite    = 1'b0;
            MemBubbleSel = 1'b1;
            MultBusy     = 1'b1;
            w_cnt_nxt    = r_cnt - CNT_W'(1);
            w_state_nxt  = ST_MULT_WAIT;
        end else begin
            // RUN, or the last mult cycle (cnt==0) which behaves like RUN so
            // a following mult is accepted without a gap.
            if (EX_BranchTaken) begin
                IFIDFlush     = 1'b1;
                CtrlBubbleSel = 1'b1;
            end else if (w_lu) begin
                PCWrite       = 1'b0;
                IFIDWrite     = 1'b0;
                CtrlBubbleSel = 1'b1;
            end else if (ID_Jump) begin
                // Checked ahead of mult: an illegal jump+mult acts as a jump.
                IFIDFlush = 1'b1;
            end else if (ID_IsMult) begin
                if (MULT_CYCLES > 1) begin
                    w_state_nxt = ST_MULT_WAIT;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!PCWrite && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    assign StallCycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    localparam int MC = 4;
    localparam int SW = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [4:0]    ID_Rs, ID_Rt, EX_Rd;
    logic          ID_UsesRt, ID_IsMult, ID_Jump, EX_MemRead, EX_BranchTaken;
    logic          PCWrite, IFIDWrite, IFIDFlush, IDEXWrite;
    logic          CtrlBubbleSel, MemBubbleSel, MultBusy;
    logic [SW-1:0] StallCycles;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    hazard_stall_ctrl #(.MULT_CYCLES(MC), .STALL_CNT_W(SW)) dut (
        .Clk(Clk), .Reset(Reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_IsMult(ID_IsMult), .ID_Jump(ID_Jump),
        .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .EX_BranchTaken(EX_BranchTaken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXWrite(IDEXWrite), .CtrlBubbleSel(CtrlBubbleSel),
        .MemBubbleSel(MemBubbleSel), .MultBusy(MultBusy),
        .StallCycles(StallCycles)
    );

    // Output bundle order: {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite,
    //                       CtrlBubbleSel, MemBubbleSel, MultBusy}
    localparam logic [6:0] O_RUN  = 7'b1101000;
    localparam logic [6:0] O_RST  = 7'b0000110;
    localparam logic [6:0] O_LU   = 7'b0001100;
    localparam logic [6:0] O_BR   = 7'b1111100;
    localparam logic [6:0] O_JMP  = 7'b1111000;
    localparam logic [6:0] O_WAIT = 7'b0000011;

    typedef struct {
        logic       rst_n;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       is_mult;
        logic       jump;
        logic       memread;
        logic [4:0] rd;
        logic       br;
        logic [6:0] exp_o;
        logic [SW-1:0] exp_sc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic is_mult, input logic jump,
                       input logic memread, input logic [4:0] rd, input logic br,
                       input logic [6:0] exp_o, input int exp_sc);
        vec_t v;
        v.rst_n = rst_n; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt;
        v.is_mult = is_mult; v.jump = jump; v.memread = memread; v.rd = rd;
        v.br = br; v.exp_o = exp_o; v.exp_sc = SW'(exp_sc);
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        Reset = v.rst_n; ID_Rs = v.rs; ID_Rt = v.rt; ID_UsesRt = v.uses_rt;
        ID_IsMult = v.is_mult; ID_Jump = v.jump; EX_MemRead = v.memread;
        EX_Rd = v.rd; EX_BranchTaken = v.br;
    endtask

    task automatic check(input string name, input logic [6:0] exp_o, input logic [SW-1:0] exp_sc);
        logic [6:0] act;
        act = {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, CtrlBubbleSel, MemBubbleSel, MultBusy};
        checks++;
        if (act !== exp_o) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b", name, act, exp_o);
        end
        checks++;
        if (StallCycles !== exp_sc) begin
            errors++;
            $display("FAIL %s StallCycles: got %0d expected %0d", name, StallCycles, exp_sc);
        end
    endtask

    initial begin
        vec_t v;
        //   rst rs  rt  ur ml jp mr rd  br  expected   sc
        add(0, 0,  0,  0, 0, 0, 0, 0,  0, O_RST,  0);  // 0 reset x3
        add(0, 0,  0,  0, 0, 0, 0, 0,  0, O_RST,  0);
        add(0, 0,  0,  0, 0, 0, 0, 0,  0, O_RST,  0);
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_RUN,  0);  // 3 first cycle after release
        add(1, 8,  0,  0, 0, 0, 1, 8,  0, O_LU,   0);  // 4 load-use on rs
        add(1, 8,  0,  0, 0, 0, 0, 8,  0, O_RUN,  1);  // 5 clears, one stall
        add(1, 0,  5,  1, 0, 0, 1, 5,  0, O_LU,   1);  // 6 load-use on rt
        add(1, 0,  5,  0, 0, 0, 1, 5,  0, O_RUN,  2);  // 7 rt not used -> none
        add(1, 0,  0,  0, 0, 0, 1, 0,  0, O_RUN,  2);  // 8 rd=0 -> none
        add(1, 8,  0,  0, 1, 0, 1, 8,  1, O_BR,   2);  // 9 branch beats LU+mult
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_RUN,  2);  // 10 still RUN
        add(1, 0,  0,  0, 0, 1, 0, 0,  0, O_JMP,  2);  // 11 jump
        add(1, 0,  0,  0, 1, 1, 0, 0,  0, O_JMP,  2);  // 12 jump+mult acts as jump
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_RUN,  2);  // 13 no mult wait
        add(1, 0,  0,  0, 1, 0, 0, 0,  0, O_RUN,  2);  // 14 mult accepted
        add(1, 8,  0,  0, 0, 0, 1, 8,  1, O_WAIT, 2);  // 15 cnt=3, inputs ignored
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_WAIT, 3);  // 16 cnt=2
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_WAIT, 4);  // 17 cnt=1
        add(1, 0,  0,  0, 1, 0, 0, 0,  0, O_RUN,  5);  // 18 cnt=0, second mult
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_WAIT, 5);  // 19 second hold cnt=3
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_WAIT, 6);  // 20 cnt=2
        add(0, 0,  0,  0, 0, 0, 0, 0,  0, O_RST,  7);  // 21 reset mid-wait
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_RUN,  0);  // 22 RUN after release
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_RUN,  0);  // 23
        add(1, 0,  0,  0, 1, 0, 0, 0,  0, O_RUN,  0);  // 24 mult
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_WAIT, 0);  // 25
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_WAIT, 1);  // 26
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_WAIT, 2);  // 27
        add(1, 3,  0,  0, 0, 0, 1, 3,  0, O_LU,   3);  // 28 cnt=0 with load-use
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_RUN,  4);  // 29
        add(1, 0,  0,  0, 1, 0, 0, 0,  0, O_RUN,  4);  // 30 mult
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_WAIT, 4);  // 31
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_WAIT, 5);  // 32
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_WAIT, 6);  // 33
        add(1, 0,  0,  0, 0, 1, 0, 0,  0, O_JMP,  7);  // 34 cnt=0 with jump
        add(1, 0,  0,  0, 0, 0, 0, 0,  0, O_RUN,  7);  // 35 back in RUN

        v = vecs[0];
        drive(v);
        @(posedge Clk);
        @(posedge Clk);

        for (int i = 0; i < vecs.size(); i++) begin
            #1 drive(vecs[i]);
            #2 check($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].exp_sc);
            @(posedge Clk);
        end

        // Saturation: 20 load-use stalls after a fresh reset.
        #1 v = vecs[0];
        drive(v);
        @(posedge Clk);
        @(posedge Clk);
        for (int i = 0; i < 20; i++) begin
            int exp_n;
            exp_n = (i > 15) ? 15 : i;
            #1 Reset = 1'b1; EX_MemRead = 1'b1; EX_Rd = 5'd9; ID_Rs = 5'd9;
            #2 check($sformatf("sat_lu%0d", i), O_LU, SW'(exp_n));
            @(posedge Clk);
            #1 EX_MemRead = 1'b0;
            @(posedge Clk);
        end
        #3 check("sat_final", O_RUN, SW'(15));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
